// File: rtl/clkdiv_phase_tracker.sv
// Slow-clock edge detector, period meter and lock tracker in the hclkin domain.
// Define CLKDIV_TRACK_FALL_EN to build falling-edge detection on fall_stb.
module clkdiv_phase_tracker #(
  parameter int DIV      = 4,
  parameter int LOCK_CNT = 8,
  parameter int TOL      = 0,
  parameter int CW       = 8
) (
  input  logic          hclkin,
  input  logic          rst,
  input  logic          slow_clk,
  output logic          rise_stb,
  output logic          fall_stb,
  output logic [CW-1:0] phase,
  output logic [CW-1:0] period,
  output logic          locked,
  output logic          err_stb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [CW:0] CMAX   = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0] ONE    = (CW+1)'(1);
  localparam logic [7:0]  LOCK_V = 8'(LOCK_CNT);
  localparam int          TMO    = 2 * DIV;

  logic          s1_q, s2_q, hist_q;
  logic          rise_q, err_q, locked_q, seen_q;
  logic [CW-1:0] phase_q, phase_d;
  logic [CW-1:0] period_q, period_d;
  logic [7:0]    cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic          rise_d, err_d, locked_d;
  logic          good, tmo;
  logic [CW:0]   meas;
  int            diff;

  assign rise_d = s2_q & ~hist_q;
  // meas is the length of the period ending now, one bit wider so it never wraps
  assign meas   = {1'b0, phase_q} + ONE;

  always_comb begin
    diff = int'(meas) - DIV;
    good = (diff <= TOL) && (diff >= -TOL);
    tmo  = !rise_d && (int'(meas) == TMO);
  end

  always_comb begin
    phase_d  = (meas > CMAX) ? phase_q : meas[CW-1:0];
    period_d = period_q;
    if (rise_d) begin
      phase_d = '0;
      if (seen_q)
        period_d = (meas > CMAX) ? CMAX[CW-1:0] : meas[CW-1:0];
    end
  end

  always_ff @(posedge hclkin or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      hist_q   <= 1'b0;
      rise_q   <= 1'b0;
      seen_q   <= 1'b0;
      phase_q  <= '0;
      period_q <= '0;
    end else begin
      s1_q     <= slow_clk;
      s2_q     <= s1_q;
      hist_q   <= s2_q;
      rise_q   <= rise_d;
      seen_q   <= seen_q | rise_d;
      phase_q  <= phase_d;
      period_q <= period_d;
    end
  end

  always_ff @(posedge hclkin or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // an edge always outranks the timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rise_d) begin
      unique case (state_q)
        IDLE: begin
          state_d = ACQ;
          cnt_d   = '0;
        end
        ACQ: begin
          if (good) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == LOCK_V)
              state_d = LOCKED;
          end else begin
            cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!good) begin
            cnt_d   = '0;
            state_d = ACQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    err_d    = (state_q == LOCKED) && ((rise_d && !good) || tmo);
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge hclkin or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

`ifdef CLKDIV_TRACK_FALL_EN
  logic fall_q;

  always_ff @(posedge hclkin or posedge rst) begin
    if (rst) fall_q <= 1'b0;
    else     fall_q <= ~s2_q & hist_q;
  end

  assign fall_stb = fall_q;
`else
  assign fall_stb = 1'b0;
`endif

  assign rise_stb = rise_q;
  assign phase    = phase_q;
  assign period   = period_q;
  assign locked   = locked_q;
  assign err_stb  = err_q;

endmodule

// File: tb/tb_clkdiv_phase_tracker.sv
// Bench for clkdiv_phase_tracker: TOL=0 and TOL=1 instances share one stimulus,
// both checked every cycle against an event-level reference model.
module tb_clkdiv_phase_tracker;

  localparam int DIV  = 4;
  localparam int LOCK = 8;
  localparam int SAT  = 255;

  typedef struct {
    int mode;
    int cnt;
    int since;
    int per;
    bit seen;
    bit err;
    bit rise;
    bit fall;
  } m_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slow_clk = 1'b0;
  bit         rst_req = 1'b1;

  logic       rise0, fall0, lk0, err0;
  logic       rise1, fall1, lk1, err1;
  logic [7:0] ph0, per0, ph1, per1;

  int checks = 0;
  int failures = 0;

  m_t m0, m1;
  bit sa, sb, sc;
  int rises0, lockrise0, errs0, errs1, falls, exp_falls;
  bit lk0_prev;

  clkdiv_phase_tracker #(.DIV(DIV), .LOCK_CNT(LOCK), .TOL(0), .CW(8)) dut0 (
    .hclkin(clk), .rst(rst), .slow_clk(slow_clk),
    .rise_stb(rise0), .fall_stb(fall0), .phase(ph0), .period(per0),
    .locked(lk0), .err_stb(err0)
  );

  clkdiv_phase_tracker #(.DIV(DIV), .LOCK_CNT(LOCK), .TOL(1), .CW(8)) dut1 (
    .hclkin(clk), .rst(rst), .slow_clk(slow_clk),
    .rise_stb(rise1), .fall_stb(fall1), .phase(ph1), .period(per1),
    .locked(lk1), .err_stb(err1)
  );

  always #5 clk = ~clk;

  // modes: 0 idle, 1 acquiring, 2 locked
  function automatic m_t nxt(input m_t s, input bit er, input bit ef, input int tol);
    m_t n;
    int meas, d;
    n = s;
    n.rise = er;
    n.fall = ef;
    n.err  = 1'b0;
    if (er) begin
      meas = ((s.since > SAT) ? SAT : s.since) + 1;
      if (s.seen) n.per = (meas > SAT) ? SAT : meas;
      n.seen = 1'b1;
      d = (meas > DIV) ? meas - DIV : DIV - meas;
      if (s.mode == 0) begin
        n.mode = 1;
        n.cnt  = 0;
      end else if (s.mode == 1) begin
        if (d <= tol) begin
          n.cnt = s.cnt + 1;
          if (n.cnt == LOCK) n.mode = 2;
        end else begin
          n.cnt = 0;
        end
      end else if (d > tol) begin
        n.err  = 1'b1;
        n.cnt  = 0;
        n.mode = 1;
      end
      n.since = 0;
    end else begin
      n.since = s.since + 1;
      if (n.since == 2 * DIV) begin
        if (s.mode == 2) n.err = 1'b1;
        n.mode = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int phx(input m_t m);
    return (m.since > SAT) ? SAT : m.since;
  endfunction

  task automatic chk_all();
    chk("rise0",   32'(rise0), 32'(m0.rise));
    chk("fall0",   32'(fall0), 32'(m0.fall));
    chk("phase0",  32'(ph0),   32'(phx(m0)));
    chk("period0", 32'(per0),  32'(m0.per));
    chk("locked0", 32'(lk0),   32'(m0.mode == 2));
    chk("err0",    32'(err0),  32'(m0.err));
    chk("rise1",   32'(rise1), 32'(m1.rise));
    chk("fall1",   32'(fall1), 32'(m1.fall));
    chk("phase1",  32'(ph1),   32'(phx(m1)));
    chk("period1", 32'(per1),  32'(m1.per));
    chk("locked1", 32'(lk1),   32'(m1.mode == 2));
    chk("err1",    32'(err1),  32'(m1.err));
  endtask

  task automatic mreset();
    m0 = '{default: 0};
    m1 = '{default: 0};
    sa = 1'b0;
    sb = 1'b0;
    sc = 1'b0;
  endtask

  // one hclkin cycle; the strobe trails the sampling edge by two edges
  task automatic step(input bit s);
    bit er, ef;
    @(negedge clk);
    slow_clk = s;
    rst = rst_req;
    @(posedge clk);
    #1;
    if (rst) begin
      mreset();
    end else begin
      er = sb & ~sc;
`ifdef CLKDIV_TRACK_FALL_EN
      ef = ~sb & sc;
`else
      ef = 1'b0;
`endif
      sc = sb;
      sb = sa;
      sa = s;
      m0 = nxt(m0, er, ef, 0);
      m1 = nxt(m1, er, ef, 1);
    end
    chk_all();
    if (rise0 === 1'b1) rises0++;
    if (lk0 === 1'b1 && !lk0_prev && lockrise0 == 0) lockrise0 = rises0;
    lk0_prev = (lk0 === 1'b1);
    if (err0 === 1'b1) errs0++;
    if (err1 === 1'b1) errs1++;
    if (fall0 === 1'b1) falls++;
    if (fall1 === 1'b1) falls++;
    exp_falls += int'(m0.fall) + int'(m1.fall);
  endtask

  task automatic per(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  task automatic clr();
    rises0 = 0;
    lockrise0 = 0;
    errs0 = 0;
    errs1 = 0;
  endtask

  initial begin
    int hi, lo;
    mreset();
    clr();
    falls = 0;
    exp_falls = 0;
    lk0_prev = 1'b0;

    repeat (3) step(1'b0);
    chk("rst_rise", 32'(rise0), 32'(0));
    chk("rst_phase", 32'(ph0), 32'(0));
    chk("rst_locked", 32'(lk0), 32'(0));
    rst_req = 1'b0;

    // clean divide-by-4 clock
    repeat (20) per(2, 2);
    chk("lock_at_rise", 32'(lockrise0), 32'(9));
    chk("rises20", 32'(rises0), 32'(20));
    chk("errs_clean", 32'(errs0), 32'(0));
    chk("period4", 32'(per0), 32'(4));

    // one stretched period of 6
    clr();
    per(3, 3);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("stretch_err", 32'(err0), 32'(1));
    chk("stretch_unlock", 32'(lk0), 32'(0));
    chk("stretch_per", 32'(per0), 32'(6));
    step(1'b0);
    repeat (8) per(2, 2);
    chk("relock", 32'(lk0), 32'(1));
    chk("stretch_errs", 32'(errs0), 32'(1));

    // slow clock stops
    clr();
    repeat (300) step(1'b0);
    chk("tmo_errs", 32'(errs0), 32'(1));
    chk("tmo_locked", 32'(lk0), 32'(0));
    chk("tmo_phase", 32'(ph0), 32'(255));

    // reset mid-period while locked
    repeat (12) per(2, 2);
    chk("pre_rst_lock", 32'(lk0), 32'(1));
    step(1'b1);
    @(negedge clk);
    rst = 1'b1;
    rst_req = 1'b1;
    #1;
    chk("arst_locked", 32'(lk0), 32'(0));
    chk("arst_period", 32'(per0), 32'(0));
    chk("arst_phase", 32'(ph0), 32'(0));
    chk("arst_rise", 32'(rise0), 32'(0));
    mreset();
    step(1'b1);
    rst_req = 1'b0;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("post_rst_rise", 32'(rise0), 32'(1));
    chk("post_rst_per", 32'(per0), 32'(0));
    repeat (4) per(2, 2);

    // alternating 3/5 periods: only the TOL=1 instance locks
    clr();
    repeat (10) begin
      per(2, 1);
      per(3, 2);
    end
    chk("alt_lock1", 32'(lk1), 32'(1));
    chk("alt_errs1", 32'(errs1), 32'(0));
    chk("alt_lock0", 32'(lk0), 32'(0));

    // edge landing on the timeout threshold
    per(4, 4);
    per(4, 4);

    // random periods with occasional gaps long enough to time out
    repeat (40) begin
      hi = int'($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) lo = int'($urandom_range(6, 12));
      else lo = int'($urandom_range(1, 4));
      per(hi, lo);
    end

    chk("fall_count", 32'(falls), 32'(exp_falls));
`ifndef CLKDIV_TRACK_FALL_EN
    chk("fall_none", 32'(falls), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
